// File: rtl/vga_shape_ctrl.sv
// rtl/vga_shape_ctrl.sv - frame-synchronous shape parameter controller with shadow registers
// Optional animation (radius pulse, horizontal bounce) compiled in with VGA_SHAPE_ANIM_EN.
module vga_shape_ctrl #(
   parameter int W          = 12,
   parameter int HRES       = 640,
   parameter int VRES       = 480,
   parameter int R_INIT     = 100,
   parameter int THICK_INIT = 4,
   parameter int R_MIN      = 16,
   parameter int R_MAX      = 200,
   parameter int STEP       = 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_vblank,
   input  logic [1:0]   i_sel,
   input  logic         i_wr_valid,
   input  logic [1:0]   i_wr_addr,
   input  logic [W-1:0] i_wr_data,
   output logic         o_wr_ready,
   output logic [W-1:0] o_radius,
   output logic [W-1:0] o_cx,
   output logic [W-1:0] o_cy,
   output logic [W-1:0] o_thick,
   output logic [W-1:0] o_frame,
   output logic         o_commit
);

   localparam logic [W-1:0] RAD_INIT = W'(R_INIT);
   localparam logic [W-1:0] CX_INIT  = W'(HRES / 2);
   localparam logic [W-1:0] CY_INIT  = W'(VRES / 2);
   localparam logic [W-1:0] TH_INIT  = W'(THICK_INIT);
   localparam logic [W-1:0] RAD_LO   = W'(R_MIN);
   localparam logic [W-1:0] RAD_HI   = W'(R_MAX);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMMIT,
      S_BLANK
   } state_t;

   state_t state, state_nxt;
   logic   vblank_q;
   logic   wr_fire;

   logic [W-1:0] sh_radius, sh_cx, sh_cy, sh_thick;
   logic [3:0]   dirty;
   logic [W-1:0] wr_radius;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= S_IDLE;
         vblank_q <= 1'b1;
      end else begin
         state    <= state_nxt;
         vblank_q <= i_vblank;
      end
   end

   always_comb begin
      state_nxt  = state;
      o_wr_ready = 1'b1;
      o_commit   = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_vblank && !vblank_q) state_nxt = S_COMMIT;
         end
         S_COMMIT: begin
            o_wr_ready = 1'b0;
            o_commit   = 1'b1;
            state_nxt  = S_BLANK;
         end
         S_BLANK: begin
            if (!i_vblank) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign wr_fire   = i_wr_valid && o_wr_ready;
   assign wr_radius = (i_wr_data < RAD_LO) ? RAD_LO :
                      (i_wr_data > RAD_HI) ? RAD_HI : i_wr_data;

`ifdef VGA_SHAPE_ANIM_EN
   localparam logic [W-1:0] CX_LO = W'(R_MAX);
   localparam logic [W-1:0] CX_HI = W'(HRES - 1 - R_MAX);

   logic         r_dir_up, cx_dir_right;
   logic [W:0]   r_anim, cx_anim;

   // Returns {next_direction, next_value}; reverses instead of leaving [lo, hi].
   function automatic logic [W:0] bounce_step(input logic [W-1:0] v, input logic up,
                                              input logic [W-1:0] lo, input logic [W-1:0] hi);
      logic [W:0] up_v;
      logic [W:0] lo_lim;
      up_v   = {1'b0, v} + (W+1)'(STEP);
      lo_lim = {1'b0, lo} + (W+1)'(STEP);
      if (up) begin
         if (up_v > {1'b0, hi}) return {1'b0, v - W'(STEP)};
         else                   return {1'b1, up_v[W-1:0]};
      end else begin
         if ({1'b0, v} < lo_lim) return {1'b1, up_v[W-1:0]};
         else                    return {1'b0, v - W'(STEP)};
      end
   endfunction

   assign r_anim  = bounce_step(o_radius, r_dir_up, RAD_LO, RAD_HI);
   assign cx_anim = bounce_step(o_cx, cx_dir_right, CX_LO, CX_HI);
`else
   logic unused_sel;
   assign unused_sel = ^i_sel;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sh_radius <= RAD_INIT;
         sh_cx     <= CX_INIT;
         sh_cy     <= CY_INIT;
         sh_thick  <= TH_INIT;
         dirty     <= '0;
         o_radius  <= RAD_INIT;
         o_cx      <= CX_INIT;
         o_cy      <= CY_INIT;
         o_thick   <= TH_INIT;
         o_frame   <= '0;
`ifdef VGA_SHAPE_ANIM_EN
         r_dir_up     <= 1'b1;
         cx_dir_right <= 1'b1;
`endif
      end else begin
         // Writes and commits never coincide: ready is low throughout COMMIT.
         if (wr_fire) begin
            dirty[i_wr_addr] <= 1'b1;
            case (i_wr_addr)
               2'd0:    sh_radius <= wr_radius;
               2'd1:    sh_cx     <= i_wr_data;
               2'd2:    sh_cy     <= i_wr_data;
               default: sh_thick  <= i_wr_data;
            endcase
         end
         if (state == S_COMMIT) begin
            dirty   <= '0;
            o_frame <= o_frame + 1'b1;
            if (dirty[2]) o_cy    <= sh_cy;
            if (dirty[3]) o_thick <= sh_thick;
`ifdef VGA_SHAPE_ANIM_EN
            if (dirty[0])      o_radius <= sh_radius;
            else if (i_sel[0]) {r_dir_up, o_radius} <= r_anim;
            if (dirty[1])      o_cx <= sh_cx;
            else if (i_sel[1]) {cx_dir_right, o_cx} <= cx_anim;
`else
            if (dirty[0]) o_radius <= sh_radius;
            if (dirty[1]) o_cx     <= sh_cx;
`endif
         end
      end
   end

endmodule

// File: tb/tb_vga_shape_ctrl.sv
// tb/tb_vga_shape_ctrl.sv - scoreboard bench for vga_shape_ctrl
// Expected parameter sets are queued per frame and compared after each commit pulse.
module tb_vga_shape_ctrl;

`ifdef VGA_SHAPE_ANIM_EN
   localparam bit ANIM = 1'b1;
`else
   localparam bit ANIM = 1'b0;
`endif

   logic        i_clk;
   logic        i_rst_n;
   logic        i_vblank;
   logic [1:0]  i_sel;
   logic        i_wr_valid;
   logic [1:0]  i_wr_addr;
   logic [11:0] i_wr_data;
   logic        o_wr_ready;
   logic [11:0] o_radius, o_cx, o_cy, o_thick, o_frame;
   logic        o_commit;

   vga_shape_ctrl dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_vblank   (i_vblank),
      .i_sel      (i_sel),
      .i_wr_valid (i_wr_valid),
      .i_wr_addr  (i_wr_addr),
      .i_wr_data  (i_wr_data),
      .o_wr_ready (o_wr_ready),
      .o_radius   (o_radius),
      .o_cx       (o_cx),
      .o_cy       (o_cy),
      .o_thick    (o_thick),
      .o_frame    (o_frame),
      .o_commit   (o_commit)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [11:0] r;
      logic [11:0] cx;
      logic [11:0] cy;
      logic [11:0] th;
      logic [11:0] fr;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   logic [11:0] frame_exp = 0;
   logic [11:0] prev_radius = 12'd100;
   bit          commit_seen = 1'b0;
   logic [11:0] r_cur;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push(input logic [11:0] r, input logic [11:0] cx,
                       input logic [11:0] cy, input logic [11:0] th);
      exp_t e;
      frame_exp = frame_exp + 1'b1;
      e.r = r; e.cx = cx; e.cy = cy; e.th = th; e.fr = frame_exp;
      sb.push_back(e);
   endtask

   task automatic host_write(input logic [1:0] addr, input logic [11:0] data);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge i_clk);
         if (o_wr_ready) begin
            i_wr_valid = 1'b1;
            i_wr_addr  = addr;
            i_wr_data  = data;
            @(posedge i_clk);
            #1 i_wr_valid = 1'b0;
            done = 1'b1;
         end
      end
      check("write_timeout", done, 1);
   endtask

   task automatic vb_fall();
      @(negedge i_clk);
      i_vblank = 1'b0;
      repeat (3) @(negedge i_clk);
   endtask

   task automatic vb_rise_wait();
      @(negedge i_clk);
      i_vblank = 1'b1;
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge i_clk);
      check("commit_timeout", sb.size(), 0);
      repeat (2) @(negedge i_clk);
   endtask

   // Monitor: a commit seen at one falling edge is scored at the next one.
   always @(negedge i_clk) begin : mon
      exp_t e;
      if (commit_seen) begin
         check("q_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("radius", o_radius, e.r);
            check("cx", o_cx, e.cx);
            check("cy", o_cy, e.cy);
            check("thick", o_thick, e.th);
            check("frame", o_frame, e.fr);
            prev_radius = e.r;
         end
         check("commit_len", o_commit, 0);
      end
      if (o_commit) begin
         check("pre_radius", o_radius, prev_radius);
         check("ready_in_commit", o_wr_ready, 0);
      end
      commit_seen = o_commit && i_rst_n;
   end

   initial begin
      i_rst_n    = 1'b0;
      i_vblank   = 1'b1;
      i_sel      = 2'b00;
      i_wr_valid = 1'b0;
      i_wr_addr  = 2'd0;
      i_wr_data  = 12'd0;
      repeat (3) @(negedge i_clk);
      check("rst_radius", o_radius, 100);
      check("rst_cx", o_cx, 320);
      check("rst_cy", o_cy, 240);
      check("rst_thick", o_thick, 4);
      check("rst_frame", o_frame, 0);
      check("rst_commit", o_commit, 0);
      check("rst_ready", o_wr_ready, 1);
      i_rst_n = 1'b1;
      repeat (6) @(negedge i_clk);

      vb_fall();
      push(100, 320, 240, 4);
      vb_rise_wait();

      vb_fall();
      host_write(2'd0, 12'd150);
      push(150, 320, 240, 4);
      vb_rise_wait();

      vb_fall();
      host_write(2'd0, 12'd5);
      push(16, 320, 240, 4);
      vb_rise_wait();

      vb_fall();
      host_write(2'd0, 12'd300);
      push(200, 320, 240, 4);
      vb_rise_wait();

      host_write(2'd1, 12'd50);
      @(negedge i_clk);
      check("blank_cx_hold", o_cx, 320);
      vb_fall();
      host_write(2'd2, 12'd100);
      host_write(2'd3, 12'd7);
      host_write(2'd0, 12'd120);
      host_write(2'd0, 12'd130);
      push(130, 50, 100, 7);
      vb_rise_wait();

      i_sel = 2'b01;
      vb_fall();
      host_write(2'd0, 12'd199);
      push(199, 50, 100, 7);
      vb_rise_wait();
      vb_fall(); push(ANIM ? 12'd200 : 12'd199, 50, 100, 7); vb_rise_wait();
      vb_fall(); push(12'd199, 50, 100, 7);                  vb_rise_wait();
      vb_fall(); push(ANIM ? 12'd198 : 12'd199, 50, 100, 7); vb_rise_wait();
      r_cur = ANIM ? 12'd198 : 12'd199;

      i_sel = 2'b10;
      vb_fall();
      host_write(2'd1, 12'd439);
      push(r_cur, 439, 100, 7);
      vb_rise_wait();
      vb_fall(); push(r_cur, ANIM ? 12'd438 : 12'd439, 100, 7); vb_rise_wait();

      i_sel = 2'b00;
      vb_fall();
      host_write(2'd0, 12'd150);
      @(negedge i_clk);
      i_vblank = 1'b1;
      for (int i = 0; i < 10 && !o_commit; i++) begin
         @(posedge i_clk);
         #1;
      end
      check("reached_commit", o_commit, 1);
      i_rst_n = 1'b0;
      #1;
      check("mid_rst_radius", o_radius, 100);
      check("mid_rst_cx", o_cx, 320);
      check("mid_rst_frame", o_frame, 0);
      check("mid_rst_commit", o_commit, 0);
      check("mid_rst_ready", o_wr_ready, 1);
      frame_exp   = 0;
      prev_radius = 12'd100;
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      repeat (4) @(negedge i_clk);
      vb_fall();
      push(100, 320, 240, 4);
      vb_rise_wait();

      repeat (4) @(negedge i_clk);
      check("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
